// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data memory unit.
//   - MEM_type transfer-size encodings
//   - MMIO register offsets relative to MMIO_BASE
//   - UART transmitter state enum
//   - access-size decode and alignment helpers
package dmem_pkg;

    localparam logic [2:0] MT_BYTE  = 3'b000;
    localparam logic [2:0] MT_HALF  = 3'b001;
    localparam logic [2:0] MT_WORD  = 3'b010;
    localparam logic [2:0] MT_BYTEU = 3'b100;
    localparam logic [2:0] MT_HALFU = 3'b101;

    localparam logic [31:0] MMIO_OFF_CNT  = 32'd0;
    localparam logic [31:0] MMIO_OFF_UART = 32'd4;
    localparam logic [31:0] MMIO_OFF_STAT = 32'd8;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } acc_size_e;

    // Unlisted encodings (011, 110, 111) fall through to word access.
    function automatic acc_size_e decode_size(input logic [2:0] mt);
        acc_size_e sz;
        case (mt)
            MT_BYTE, MT_BYTEU: sz = SZ_BYTE;
            MT_HALF, MT_HALFU: sz = SZ_HALF;
            default:           sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] lane);
        logic mis;
        case (sz)
            SZ_HALF: mis = lane[0];
            SZ_WORD: mis = (lane != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: 8N1 serial transmitter, LSB first, CLK_PER_BIT clocks per bit.
// Ports:
//   CLK   in   clock, rising edge
//   rst   in   asynchronous active-low reset (aborts any frame, tx returns high)
//   start in   request a frame; honoured only in IDLE
//   data  in   byte to send, captured with start
//   tx    out  serial line, idle high
//   busy  out  high whenever a frame is in progress
module uart_tx_fsm
    import dmem_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned BW = $clog2(CLK_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);

    uart_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q <= UART_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        case (state_q)
            UART_IDLE: begin
                if (start) begin
                    state_d = UART_START;
                    sh_d    = data;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            UART_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = UART_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            UART_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    sh_d   = {1'b0, sh_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = UART_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            UART_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = UART_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    // Line level is decoded from the state register so reset drives it high
    // immediately, without waiting for a clock edge.
    always_comb begin
        case (state_q)
            UART_START: tx = 1'b0;
            UART_DATA:  tx = sh_q[0];
            default:    tx = 1'b1;
        endcase
    end

    assign busy = (state_q != UART_IDLE);

endmodule

// File: rtl/data_mem_unit.sv
// data_mem_unit: CPU data memory with byte/half/word access and an MMIO window.
// Optional feature macro: UART_TX_EN (UART transmitter at MMIO_BASE+4/+8).
// Ports:
//   CLK          in   clock, rising edge
//   rst          in   asynchronous active-low reset (RAM contents are kept)
//   MEM_addr     in   byte address
//   MEM_WR_out   in   store data, right-aligned
//   MEM_type     in   transfer size (see dmem_pkg MT_*)
//   MEM_rd_en    in   load request
//   MEM_wr_en    in   store request (wins over load)
//   MEM_data     out  load data, right-aligned, zero-filled, combinational
//   uart_tx      out  serial transmit line, idle high
//   misalign_err out  sticky misaligned-access flag
// MMIO map: +0 cycle counter (RO), +4 UART TX data (WO), +8 status (bit0 busy).
module data_mem_unit
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int unsigned CLK_PER_BIT = 16
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [31:0] MEM_addr,
    input  logic [31:0] MEM_WR_out,
    input  logic [2:0]  MEM_type,
    input  logic        MEM_rd_en,
    input  logic        MEM_wr_en,
    output logic [31:0] MEM_data,
    output logic        uart_tx,
    output logic        misalign_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [31:0] ram_q [DEPTH_WORDS];
    logic [31:0] cyc_q;
    logic        err_q;

    acc_size_e   size;
    logic [1:0]  lane;
    logic        mis;
    logic        is_mmio;
    logic [31:0] mmio_off;
    logic [AW-1:0] word_idx;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ram_rdata;
    logic [31:0] mmio_rdata;
    logic        uart_busy;

    assign size     = decode_size(MEM_type);
    assign lane     = MEM_addr[1:0];
    assign mis      = is_misaligned(size, lane);
    assign is_mmio  = (MEM_addr >= MMIO_BASE);
    assign mmio_off = MEM_addr - MMIO_BASE;
    // Upper address bits are ignored, so RAM aliases every DEPTH_WORDS*4 bytes.
    assign word_idx = MEM_addr[AW+1:2];

    // Store data is replicated across lanes so the byte enables alone pick
    // which bytes land.
    always_comb begin
        be    = '0;
        wdata = '0;
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << lane;
                wdata = {4{MEM_WR_out[7:0]}};
            end
            SZ_HALF: begin
                be    = 4'b0011 << lane;
                wdata = {2{MEM_WR_out[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = MEM_WR_out;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (MEM_wr_en && !is_mmio && !mis) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    ram_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        ram_rdata = ram_q[word_idx] >> {lane, 3'b000};
        case (size)
            SZ_BYTE: ram_rdata = ram_rdata & 32'h0000_00FF;
            SZ_HALF: ram_rdata = ram_rdata & 32'h0000_FFFF;
            default: ;
        endcase
    end

    always_comb begin
        mmio_rdata = '0;
        if (mmio_off == MMIO_OFF_CNT) begin
            mmio_rdata = cyc_q;
        end else if (mmio_off == MMIO_OFF_STAT) begin
            mmio_rdata = {31'b0, uart_busy};
        end
    end

    always_comb begin
        MEM_data = '0;
        if (MEM_rd_en && !MEM_wr_en && !mis) begin
            MEM_data = is_mmio ? mmio_rdata : ram_rdata;
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            cyc_q <= '0;
            err_q <= 1'b0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if ((MEM_rd_en || MEM_wr_en) && mis) begin
                err_q <= 1'b1;
            end
        end
    end

    assign misalign_err = err_q;

`ifdef UART_TX_EN
    logic uart_start;

    assign uart_start = MEM_wr_en && is_mmio && !mis && (mmio_off == MMIO_OFF_UART);

    uart_tx_fsm #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_uart (
        .CLK  (CLK),
        .rst  (rst),
        .start(uart_start),
        .data (MEM_WR_out[7:0]),
        .tx   (uart_tx),
        .busy (uart_busy)
    );
`else
    assign uart_tx   = 1'b1;
    assign uart_busy = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: scoreboard bench for data_mem_unit.
// The driver computes each expected load/flag value from a byte-array memory
// model and pushes it to a queue; a monitor pops on the mid-cycle edge.
module tb_data_mem_unit;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam int unsigned CPB   = 4;
    localparam int unsigned NBYTES = DEPTH * 4;

    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] MEM_addr = '0;
    logic [31:0] MEM_WR_out = '0;
    logic [2:0]  MEM_type = 3'b010;
    logic        MEM_rd_en = 1'b0;
    logic        MEM_wr_en = 1'b0;
    logic [31:0] MEM_data;
    logic        uart_tx;
    logic        misalign_err;

    data_mem_unit #(
        .DEPTH_WORDS(DEPTH),
        .MMIO_BASE  (BASE),
        .CLK_PER_BIT(CPB)
    ) dut (
        .CLK         (CLK),
        .rst         (rst),
        .MEM_addr    (MEM_addr),
        .MEM_WR_out  (MEM_WR_out),
        .MEM_type    (MEM_type),
        .MEM_rd_en   (MEM_rd_en),
        .MEM_wr_en   (MEM_wr_en),
        .MEM_data    (MEM_data),
        .uart_tx     (uart_tx),
        .misalign_err(misalign_err)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        string       name;
    } exp_t;

    exp_t       sbq[$];
    logic       issued = 1'b0;
    logic [7:0] mdl_mem [NBYTES];
    logic       mdl_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int unsigned size_of(input logic [2:0] t);
        case (t)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // One transaction per cycle; inputs change 1 time unit after the rising edge.
    task automatic op(input logic [31:0] addr, input logic [2:0] t, input logic [31:0] wd,
                      input logic rd, input logic wr, input logic [31:0] mmio_exp,
                      input string name);
        exp_t e;
        int unsigned sz, b;
        logic m, mmio;
        @(posedge CLK);
        #1;
        MEM_addr = addr; MEM_type = t; MEM_WR_out = wd;
        MEM_rd_en = rd; MEM_wr_en = wr;
        sz   = size_of(t);
        m    = (addr % sz) != 0;
        mmio = addr >= BASE;
        b    = addr % NBYTES;
        e.err  = mdl_err;
        e.name = name;
        e.data = '0;
        if (rd && !wr && !m) begin
            if (mmio) e.data = mmio_exp;
            else for (int unsigned i = 0; i < sz; i++) e.data = e.data | (32'(mdl_mem[b+i]) << (8*i));
        end
        if (wr && !m && !mmio) begin
            for (int unsigned i = 0; i < sz; i++) mdl_mem[b+i] = 8'(wd >> (8*i));
        end
        if ((rd || wr) && m) mdl_err = 1'b1;
        sbq.push_back(e);
        issued = 1'b1;
    endtask

    task automatic idle();
        @(posedge CLK);
        #1;
        MEM_rd_en = 1'b0; MEM_wr_en = 1'b0;
        issued = 1'b0;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (issued) begin
            if (sbq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL sb_underflow: got empty queue expected an entry");
            end else begin
                e = sbq.pop_front();
                check({e.name, "_data"}, MEM_data, e.data);
                check({e.name, "_err"}, {31'b0, misalign_err}, {31'b0, e.err});
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v1, v2, a, d;
        logic [2:0]  t;
        logic [9:0]  frame;
        logic        exp_tx, exp_busy;
        int unsigned sz, r;

        // Reset state
        MEM_addr = BASE; MEM_rd_en = 1'b1;
        #12;
        check("rst_tx", {31'b0, uart_tx}, 32'd1);
        check("rst_err", {31'b0, misalign_err}, 32'd0);
        check("rst_cnt", MEM_data, 32'd0);
        MEM_rd_en = 1'b0;
        @(negedge CLK);
        rst = 1'b1;

        // Known RAM contents
        for (int unsigned w = 0; w < DEPTH; w++) op(w * 4, 3'b010, $urandom, 1'b0, 1'b1, '0, "fill");

        // Directed loads/stores
        op(32'h100, 3'b010, 32'hDEADBEEF, 1'b0, 1'b1, '0, "sw100");
        op(32'h100, 3'b010, '0, 1'b1, 1'b0, '0, "lw100");
        op(32'h101, 3'b000, 32'h0000005A, 1'b0, 1'b1, '0, "sb101");
        op(32'h100, 3'b010, '0, 1'b1, 1'b0, '0, "lw100b");
        op(32'h101, 3'b100, '0, 1'b1, 1'b0, '0, "lbu101");
        op(32'h100 + NBYTES, 3'b010, '0, 1'b1, 1'b0, '0, "lw_alias");
        op(32'h200, 3'b111, 32'h12345678, 1'b1, 1'b1, '0, "rdwr_both");
        op(32'h202, 3'b101, '0, 1'b1, 1'b0, '0, "lhu202");

        // Randomized aligned traffic across aliased addresses
        for (int n = 0; n < 300; n++) begin
            t  = 3'($urandom_range(0, 7));
            sz = size_of(t);
            a  = $urandom & 32'h7FFF_FFFF;
            a  = a - (a % sz);
            r  = $urandom_range(0, 3);
            op(a, t, $urandom, (r != 1), (r == 1 || r == 2), '0, "rand");
        end
        idle();

        // Cycle counter
        MEM_addr = BASE; MEM_type = 3'b010; MEM_rd_en = 1'b1;
        @(negedge CLK); v1 = MEM_data;
        @(negedge CLK); v2 = MEM_data;
        check("cnt_inc", v2, v1 + 32'd1);
        force dut.cyc_q = 32'hFFFF_FFFF;
        #1;
        check("cnt_force", MEM_data, 32'hFFFF_FFFF);
        release dut.cyc_q;
        @(posedge CLK); #1;
        check("cnt_wrap", MEM_data, 32'd0);
        MEM_addr = BASE + 32'd12;
        #1;
        check("mmio_unmapped", MEM_data, 32'd0);
        MEM_rd_en = 1'b0;

        // UART frame, with a dropped write mid-frame
        frame = {1'b1, 8'hA5, 1'b0};
        op(BASE + 32'd4, 3'b010, 32'h000000A5, 1'b0, 1'b1, '0, "uart_wr");
        for (int k = 0; k < 40; k++) begin
`ifdef UART_TX_EN
            exp_tx = frame[k/4]; exp_busy = 1'b1;
`else
            exp_tx = 1'b1; exp_busy = 1'b0;
`endif
            if (k == 10) op(BASE + 32'd4, 3'b010, 32'h0000003C, 1'b0, 1'b1, '0, "uart_wr_busy");
            else op(BASE + 32'd8, 3'b010, '0, 1'b1, 1'b0, {31'b0, exp_busy}, "uart_stat");
            @(negedge CLK);
            check("uart_bit", {31'b0, uart_tx}, {31'b0, exp_tx});
        end
        op(BASE + 32'd8, 3'b010, '0, 1'b1, 1'b0, 32'd0, "uart_done");
        @(negedge CLK);
        check("uart_idle_tx", {31'b0, uart_tx}, 32'd1);

        // Misaligned access
        op(32'h103, 3'b001, 32'h0000FFFF, 1'b0, 1'b1, '0, "sh103");
        op(32'h100, 3'b010, '0, 1'b1, 1'b0, '0, "lw_after_sh");
        op(32'h101, 3'b010, '0, 1'b1, 1'b0, '0, "lw_mis");
        op(32'h102, 3'b001, '0, 1'b1, 1'b0, '0, "lh102");
        op(32'h104, 3'b010, '0, 1'b1, 1'b0, '0, "err_held");

        // Reset in the middle of a frame
        op(BASE + 32'd4, 3'b010, 32'h00000081, 1'b0, 1'b1, '0, "uart_wr2");
        idle();
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        MEM_addr = BASE + 32'd8; MEM_type = 3'b010; MEM_rd_en = 1'b1;
        #1;
`ifdef UART_TX_EN
        check("pre_rst_busy", MEM_data, 32'd1);
`else
        check("pre_rst_busy", MEM_data, 32'd0);
`endif
        check("pre_rst_err", {31'b0, misalign_err}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_tx", {31'b0, uart_tx}, 32'd1);
        check("mid_rst_busy", MEM_data, 32'd0);
        check("mid_rst_err", {31'b0, misalign_err}, 32'd0);
        MEM_addr = BASE;
        #1;
        check("mid_rst_cnt", MEM_data, 32'd0);
        MEM_rd_en = 1'b0;
        mdl_err = 1'b0;
        @(negedge CLK);
        rst = 1'b1;

        // RAM survives reset
        op(32'h100, 3'b010, '0, 1'b1, 1'b0, '0, "ram_kept");
        d = $urandom;
        op(32'h3FC, 3'b110, d, 1'b0, 1'b1, '0, "sw_top");
        op(32'h3FC, 3'b010, '0, 1'b1, 1'b0, '0, "lw_top");
        op(32'h3FE, 3'b000, '0, 1'b1, 1'b0, '0, "lb_top");
        idle();
        @(negedge CLK);
        if (sbq.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
